// File: rtl/scan_sync_tracker.sv
// Scanner sync conditioner: synchronises the raw sync line, validates half-scan
// boundaries, keeps the free-running timestamp and per-direction IIR averages.
module scan_sync_tracker #(
  parameter logic [31:0] TIME_INIT  = 32'd0,
  parameter logic [31:0] MIN_HALF   = 32'd1000,
  parameter logic [31:0] MAX_HALF   = 32'd1_000_000,
  parameter int unsigned AVG_SHIFT  = 4,
  parameter int unsigned TOL_SHIFT  = 3,
  parameter int unsigned LOCK_COUNT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_scan_sync_raw,
  output logic [31:0] o_sig_time,
  output logic        o_sync_start,
  output logic        o_dir,
  output logic [31:0] o_afll_ltr,
  output logic [31:0] o_afll_rtl,
  output logic        o_locked,
  output logic [15:0] o_glitch_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;

  state_t           r_state, w_state_nx;
  logic             r_sync1, r_sync_s, r_sync_d;
  logic [31:0]      r_time, r_last_edge;
  logic             r_acc_level, r_dir, r_sync_start;
  logic [15:0]      r_glitch_count;
  logic [1:0]       r_seed, w_seed_nx;
  logic [7:0]       r_good, w_good_nx;
  logic [1:0][31:0] r_avg, w_avg_nx;

  logic               w_edge, w_new_lvl, w_accept, w_glitch, w_timeout, w_big, w_intol;
  logic [31:0]        w_interval, w_avg_cur, w_iir;
  logic signed [32:0] w_diff, w_iir_step;
  logic [32:0]        w_absdiff;

  assign w_edge     = r_sync_s ^ r_sync_d;
  assign w_interval = r_time - r_last_edge;
  assign w_new_lvl  = r_sync_s != r_acc_level;
  assign w_accept   = w_edge && ((r_state == S_IDLE) || (w_new_lvl && w_interval >= MIN_HALF));
  assign w_glitch   = w_edge && (r_state != S_IDLE) && w_new_lvl && (w_interval < MIN_HALF);
  assign w_timeout  = !w_edge && (r_state != S_IDLE) && (w_interval > MAX_HALF);
  assign w_big      = w_interval > MAX_HALF;

  // Index 0 = LTR, 1 = RTL; the half that just ended matches the new level.
  assign w_avg_cur  = r_avg[r_sync_s];
  assign w_diff     = $signed({1'b0, w_interval}) - $signed({1'b0, w_avg_cur});
  assign w_absdiff  = w_diff[32] ? 33'(-w_diff) : 33'(w_diff);
  assign w_intol    = w_absdiff <= {1'b0, w_avg_cur >> TOL_SHIFT};
  assign w_iir_step = w_diff >>> AVG_SHIFT;
  assign w_iir      = w_avg_cur + 32'(w_iir_step);

  always_comb begin
    w_state_nx = r_state;
    w_seed_nx  = r_seed;
    w_good_nx  = r_good;
    w_avg_nx   = r_avg;
    if (w_accept) begin
      unique case (r_state)
        S_IDLE: w_state_nx = S_ACQUIRE;
        S_ACQUIRE: begin
          if (w_big) begin
            w_seed_nx = '0;
            w_good_nx = '0;
          end else if (!r_seed[r_sync_s]) begin
            w_avg_nx[r_sync_s]  = w_interval;
            w_seed_nx[r_sync_s] = 1'b1;
          end else if (w_intol) begin
            w_avg_nx[r_sync_s] = w_iir;
            w_good_nx          = r_good + 8'd1;
            if ((&r_seed) && ({24'd0, w_good_nx} >= LOCK_COUNT)) w_state_nx = S_LOCKED;
          end else begin
            w_avg_nx[r_sync_s] = w_interval;
            w_good_nx          = '0;
          end
        end
        S_LOCKED: begin
          // Losing lock keeps the averages; only an over-long half drops the seeds.
          if (w_big || !w_intol) begin
            w_state_nx = S_ACQUIRE;
            w_good_nx  = '0;
            if (w_big) w_seed_nx = '0;
          end else begin
            w_avg_nx[r_sync_s] = w_iir;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_seed_nx  = '0;
      w_good_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1        <= 1'b0;
      r_sync_s       <= 1'b0;
      r_sync_d       <= 1'b0;
      r_time         <= TIME_INIT;
      r_last_edge    <= '0;
      r_acc_level    <= 1'b0;
      r_dir          <= 1'b0;
      r_sync_start   <= 1'b0;
      r_glitch_count <= '0;
      r_state        <= S_IDLE;
      r_seed         <= '0;
      r_good         <= '0;
      r_avg          <= '0;
    end else begin
      r_sync1      <= i_scan_sync_raw;
      r_sync_s     <= r_sync1;
      r_sync_d     <= r_sync_s;
      r_time       <= r_time + 32'd1;
      r_sync_start <= w_accept;
      r_state      <= w_state_nx;
      r_seed       <= w_seed_nx;
      r_good       <= w_good_nx;
      r_avg        <= w_avg_nx;
      if (w_accept) begin
        r_last_edge <= r_time;
        r_acc_level <= r_sync_s;
        r_dir       <= ~r_sync_s;
      end
      if (w_glitch && (r_glitch_count != 16'hFFFF)) r_glitch_count <= r_glitch_count + 16'd1;
    end
  end

  assign o_sig_time     = r_time;
  assign o_sync_start   = r_sync_start;
  assign o_dir          = r_dir;
  assign o_afll_ltr     = r_avg[0];
  assign o_afll_rtl     = r_avg[1];
  assign o_locked       = (r_state == S_LOCKED);
  assign o_glitch_count = r_glitch_count;

endmodule

// File: tb/tb_scan_sync_tracker.sv
// Bench for scan_sync_tracker: event-level reference model feeds an expectation
// queue; a monitor pops one entry per sync_start from two instances (one wrapping).
module tb_scan_sync_tracker;
  localparam logic [31:0] MIN_H = 32'd100;
  localparam logic [31:0] MAX_H = 32'd10000;
  localparam int unsigned AVG   = 2;
  localparam int unsigned TOL   = 3;
  localparam int unsigned LOCKN = 4;
  localparam logic [31:0] TI_B  = 32'hFFFF_FE00;

  logic clk = 1'b0, rst_n = 1'b0, raw = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_time, a_ltr, a_rtl, b_time, b_ltr, b_rtl;
  logic        a_ss, a_dir, a_lk, b_ss, b_dir, b_lk;
  logic [15:0] a_gc, b_gc;

  scan_sync_tracker #(.TIME_INIT(32'd0), .MIN_HALF(MIN_H), .MAX_HALF(MAX_H),
    .AVG_SHIFT(AVG), .TOL_SHIFT(TOL), .LOCK_COUNT(LOCKN)) dut_a (
    .clk(clk), .reset_n(rst_n), .i_scan_sync_raw(raw), .o_sig_time(a_time),
    .o_sync_start(a_ss), .o_dir(a_dir), .o_afll_ltr(a_ltr), .o_afll_rtl(a_rtl),
    .o_locked(a_lk), .o_glitch_count(a_gc));

  scan_sync_tracker #(.TIME_INIT(TI_B), .MIN_HALF(MIN_H), .MAX_HALF(MAX_H),
    .AVG_SHIFT(AVG), .TOL_SHIFT(TOL), .LOCK_COUNT(LOCKN)) dut_b (
    .clk(clk), .reset_n(rst_n), .i_scan_sync_raw(raw), .o_sig_time(b_time),
    .o_sync_start(b_ss), .o_dir(b_dir), .o_afll_ltr(b_ltr), .o_afll_rtl(b_rtl),
    .o_locked(b_lk), .o_glitch_count(b_gc));

  typedef struct {
    logic        dir;
    logic [31:0] ltr;
    logic [31:0] rtl;
    logic        locked;
    logic [15:0] gc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model, driven once per raw transition (bench cycle t).
  // States: 0 idle, 1 acquiring, 2 locked. Averages: [0] LTR, [1] RTL.
  int          m_st = 0;
  logic        m_acc = 1'b0;
  logic [1:0]  m_seed = 2'b00;
  int          m_good = 0;
  logic [31:0] m_avg [2] = '{32'd0, 32'd0};
  logic [15:0] m_gc = 16'd0;
  int unsigned m_last = 0;

  function automatic void model_edge(input logic s, input int unsigned t);
    int unsigned iv;
    longint d, dev, q, dv;
    logic intol, big;
    exp_t e;
    iv = t - m_last;
    // Silence of more than MAX_H+1 cycles lets a timeout fire before this edge.
    if (m_st != 0 && iv > MAX_H + 1) begin
      m_st = 0; m_seed = 2'b00; m_good = 0;
    end
    if (m_st == 0) begin
      m_st = 1;
    end else begin
      if (s == m_acc) return;
      if (iv < MIN_H) begin
        if (m_gc != 16'hFFFF) m_gc = m_gc + 16'd1;
        return;
      end
      d     = longint'(iv) - longint'(m_avg[s]);
      dev   = (d < 0) ? -d : d;
      intol = dev <= longint'(m_avg[s] >> TOL);
      big   = iv > MAX_H;
      dv    = longint'(1) << AVG;
      q     = (d >= 0) ? d / dv : -((-d + dv - 1) / dv);
      if (m_st == 1) begin
        if (big) begin
          m_seed = 2'b00; m_good = 0;
        end else if (!m_seed[s]) begin
          m_avg[s] = iv; m_seed[s] = 1'b1;
        end else if (intol) begin
          m_avg[s] = 32'(longint'(m_avg[s]) + q);
          m_good++;
          if (m_seed == 2'b11 && m_good >= LOCKN) m_st = 2;
        end else begin
          m_avg[s] = iv; m_good = 0;
        end
      end else begin
        if (intol && !big) m_avg[s] = 32'(longint'(m_avg[s]) + q);
        else begin
          m_st = 1; m_good = 0;
          if (big) m_seed = 2'b00;
        end
      end
    end
    m_last = t;
    m_acc  = s;
    e.dir = ~s; e.ltr = m_avg[0]; e.rtl = m_avg[1]; e.locked = (m_st == 2); e.gc = m_gc;
    exp_q.push_back(e);
  endfunction

  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ss || b_ss) begin
        chk("sync_pair", 32'(a_ss), 32'(b_ss));
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sync_start: got pulse expected none (cyc %0d)", cyc);
        end else begin
          me = exp_q.pop_front();
          chk("dir_a", 32'(a_dir), 32'(me.dir));      chk("dir_b", 32'(b_dir), 32'(me.dir));
          chk("ltr_a", a_ltr, me.ltr);                chk("ltr_b", b_ltr, me.ltr);
          chk("rtl_a", a_rtl, me.rtl);                chk("rtl_b", b_rtl, me.rtl);
          chk("lock_a", 32'(a_lk), 32'(me.locked));   chk("lock_b", 32'(b_lk), 32'(me.locked));
          chk("gc_a", 32'(a_gc), 32'(me.gc));         chk("gc_b", 32'(b_gc), 32'(me.gc));
        end
      end
      if (cyc % 997 == 0) begin
        chk("sig_time_a", a_time, cyc);
        chk("sig_time_b", b_time, TI_B + cyc);
      end
    end
  end

  // Change raw at posedge+1 when the level differs, then hold for len cycles.
  task automatic drive(input logic lvl, input int unsigned len);
    if (lvl != raw) begin
      raw = lvl;
      model_edge(lvl, cyc);
    end
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp);
    chk({nm, "_a"}, va, exp);
    chk({nm, "_b"}, vb, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    logic lvl;
    int unsigned len;
    repeat (3) @(negedge clk);
    chk("rst_time_a", a_time, 32'd0);  chk("rst_time_b", b_time, TI_B);
    chk_both("rst_ss", 32'(a_ss), 32'(b_ss), 0);
    chk_both("rst_dir", 32'(a_dir), 32'(b_dir), 0);
    chk_both("rst_ltr", a_ltr, b_ltr, 0);
    chk_both("rst_rtl", a_rtl, b_rtl, 0);
    chk_both("rst_lock", 32'(a_lk), 32'(b_lk), 0);
    chk_both("rst_gc", 32'(a_gc), 32'(b_gc), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("count_a", a_time, i);
      chk("count_b", b_time, TI_B + i);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Lock on a 1000/1200 wave (instance b wraps sig_time during this)
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1000); drive(1'b0, 1200); end
    chk_both("lock_lk", 32'(a_lk), 32'(b_lk), 1);
    chk_both("lock_ltr", a_ltr, b_ltr, 1000);
    chk_both("lock_rtl", a_rtl, b_rtl, 1200);

    // Short pulse early in the RTL half is rejected
    drive(1'b1, 1000); drive(1'b0, 30); drive(1'b1, 20); drive(1'b0, 500);
    chk_both("glitch_gc", 32'(a_gc), 32'(b_gc), 1);
    chk_both("glitch_dir", 32'(a_dir), 32'(b_dir), 1);
    chk_both("glitch_lk", 32'(a_lk), 32'(b_lk), 1);
    chk_both("glitch_ltr", a_ltr, b_ltr, 1000);
    drive(1'b0, 650);

    // IIR tracking, then one outlier and relock
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1040); drive(1'b0, 1200); end
    chk_both("iir_ltr", a_ltr, b_ltr, 1022);
    drive(1'b1, 1300); drive(1'b0, 10);
    chk_both("outlier_lk", 32'(a_lk), 32'(b_lk), 0);
    chk_both("outlier_ltr", a_ltr, b_ltr, 1022);
    drive(1'b0, 1190);
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1040); drive(1'b0, 1200); end
    chk_both("relock_lk", 32'(a_lk), 32'(b_lk), 1);

    // Timeout: sync_start lands 3 cycles after the raw change; locked drops 10001 later
    k = m_last;
    while (cyc < k + 10003) @(negedge clk);
    chk_both("pre_timeout_lk", 32'(a_lk), 32'(b_lk), 1);
    @(negedge clk);
    chk_both("timeout_lk", 32'(a_lk), 32'(b_lk), 0);
    chk_both("timeout_ltr", a_ltr, b_ltr, m_avg[0]);
    chk_both("timeout_rtl", a_rtl, b_rtl, m_avg[1]);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin drive(1'b1, 1000); drive(1'b0, 1200); end
    chk_both("restart_lk", 32'(a_lk), 32'(b_lk), 1);
    chk_both("restart_ltr", a_ltr, b_ltr, 1000);
    chk_both("restart_rtl", a_rtl, b_rtl, 1200);

    // Random jittered halves with occasional short pulses
    for (int i = 0; i < 20; i++) begin
      lvl = ~raw;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 99) : $urandom_range(850, 1350);
      drive(lvl, len);
    end
    drive(raw, 20);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk_both("final_gc", 32'(a_gc), 32'(b_gc), 32'(m_gc));
    chk_both("final_lk", 32'(a_lk), 32'(b_lk), 32'(m_st == 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
